uart_rx_param: RTL and testbench

UART_RX_PARAM -- requirements
Module: uart_rx_param

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_sync2.sv | 24 ++
 rtl/uart_rx_param.sv | 153 +++++++++++++++
 tb/tb_uart_rx_param.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: FSM state encoding and legal parameter ranges.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_START      = 3'd1,
    ST_DATA       = 3'd2,
    ST_PARITY     = 3'd3,
    ST_STOP       = 3'd4,
    ST_BREAK_WAIT = 3'd5
  } rx_state_e;

  localparam int unsigned DATA_BITS_MIN  = 5;
  localparam int unsigned DATA_BITS_MAX  = 9;
  localparam int unsigned OVERSAMPLE_LO  = 8;
  localparam int unsigned OVERSAMPLE_HI  = 16;
  localparam int unsigned STOP_BITS_MIN  = 1;
  localparam int unsigned STOP_BITS_MAX  = 2;

  function automatic bit cfg_legal(input int unsigned data_bits,
                                   input int unsigned oversample,
                                   input int unsigned stop_bits);
    return (data_bits >= DATA_BITS_MIN) && (data_bits <= DATA_BITS_MAX) &&
           ((oversample == OVERSAMPLE_LO) || (oversample == OVERSAMPLE_HI)) &&
           (stop_bits >= STOP_BITS_MIN) && (stop_bits <= STOP_BITS_MAX);
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for a single asynchronous bit; resets to the idle-high level.
module uart_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/uart_rx_param.sv
// Parameterised oversampling UART receiver with parity/framing/overrun reporting
// and a one-entry output holding register acknowledged by rx_ack.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 8,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 bclkx8,
  input  logic                 rst_n,
  input  logic                 rxd,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 framing_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int unsigned CT1_W = $clog2(OVERSAMPLE);
  localparam int unsigned CT2_W = $clog2(DATA_BITS + 1);
  localparam logic [CT1_W-1:0] CT1_LAST      = CT1_W'(OVERSAMPLE - 1);
  localparam logic [CT1_W-1:0] CT1_MID       = CT1_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CT2_W-1:0] CT2_DATA_LAST = CT2_W'(DATA_BITS - 1);
  localparam logic [CT2_W-1:0] CT2_STOP_LAST = CT2_W'(STOP_BITS - 1);
  localparam bit HAS_PARITY = (PARITY_EN != 0);
  localparam bit PAR_ODD    = (PARITY_ODD != 0);

  if (!cfg_legal(DATA_BITS, OVERSAMPLE, STOP_BITS)) begin : g_cfg_check
    $error("uart_rx_param: illegal DATA_BITS/OVERSAMPLE/STOP_BITS");
  end

  rx_state_e              r_state, w_next;
  logic [CT1_W-1:0]       r_ct1;
  logic [CT2_W-1:0]       r_ct2;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_par_fault, r_frm_fault, r_done;
  logic [DATA_BITS-1:0]   r_rx_data;
  logic                   r_rx_valid, r_parity_err, r_framing_err, r_overrun_err;
  logic                   w_rxd_s, w_tick_last, w_load, w_par_exp;

  uart_sync2 u_sync (
    .clk   (bclkx8),
    .rst_n (rst_n),
    .d     (rxd),
    .q     (w_rxd_s)
  );

  assign w_tick_last = (r_ct1 == CT1_LAST);
  assign w_par_exp   = (^r_shift) ^ PAR_ODD;
  // r_done marks the cycle after the last stop sample; the word is loaded then.
  assign w_load      = (r_state == ST_STOP) && r_done;

  always_ff @(posedge bclkx8 or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:       if (!w_rxd_s) w_next = ST_START;
      ST_START:      if (r_ct1 == CT1_MID) w_next = w_rxd_s ? ST_IDLE : ST_DATA;
      ST_DATA:       if (w_tick_last && (r_ct2 == CT2_DATA_LAST))
                       w_next = HAS_PARITY ? ST_PARITY : ST_STOP;
      ST_PARITY:     if (w_tick_last) w_next = ST_STOP;
      ST_STOP:       if (r_done) w_next = r_frm_fault ? ST_BREAK_WAIT : ST_IDLE;
      ST_BREAK_WAIT: if (w_rxd_s) w_next = ST_IDLE;
      default:       w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != ST_IDLE);
  end

  always_ff @(posedge bclkx8 or negedge rst_n) begin
    if (!rst_n) begin
      r_ct1       <= '0;
      r_ct2       <= '0;
      r_shift     <= '0;
      r_par_fault <= 1'b0;
      r_frm_fault <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        ST_START: r_ct1 <= (r_ct1 == CT1_MID) ? '0 : r_ct1 + 1'b1;
        ST_DATA: begin
          r_ct1 <= w_tick_last ? '0 : r_ct1 + 1'b1;
          if (w_tick_last) begin
            r_shift <= {w_rxd_s, r_shift[DATA_BITS-1:1]};
            r_ct2   <= (r_ct2 == CT2_DATA_LAST) ? '0 : r_ct2 + 1'b1;
          end
        end
        ST_PARITY: begin
          r_ct1 <= w_tick_last ? '0 : r_ct1 + 1'b1;
          if (w_tick_last) r_par_fault <= (w_rxd_s != w_par_exp);
        end
        ST_STOP: if (!r_done) begin
          r_ct1 <= w_tick_last ? '0 : r_ct1 + 1'b1;
          if (w_tick_last) begin
            if (!w_rxd_s) r_frm_fault <= 1'b1;
            if (r_ct2 == CT2_STOP_LAST) begin
              r_done <= 1'b1;
              r_ct2  <= '0;
            end else begin
              r_ct2 <= r_ct2 + 1'b1;
            end
          end
        end
        default: begin
          r_ct1       <= '0;
          r_ct2       <= '0;
          r_done      <= 1'b0;
          r_par_fault <= 1'b0;
          r_frm_fault <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge bclkx8 or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_data     <= '0;
      r_rx_valid    <= 1'b0;
      r_parity_err  <= 1'b0;
      r_framing_err <= 1'b0;
      r_overrun_err <= 1'b0;
    end else if (w_load) begin
      r_rx_data     <= r_shift;
      r_rx_valid    <= 1'b1;
      r_parity_err  <= r_par_fault;
      r_framing_err <= r_frm_fault;
      r_overrun_err <= r_rx_valid & ~rx_ack;
    end else if (rx_ack) begin
      r_rx_valid    <= 1'b0;
      r_parity_err  <= 1'b0;
      r_framing_err <= 1'b0;
      r_overrun_err <= 1'b0;
    end
  end

  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign parity_err  = r_parity_err;
  assign framing_err = r_framing_err;
  assign overrun_err = r_overrun_err;

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench: default receiver (A) and a 7-bit, even-parity, 2-stop receiver (B).
module tb_uart_rx_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rxd_a, ack_a, rxd_b, ack_b;
  logic [7:0] a_data;
  logic [6:0] b_data;
  logic       a_valid, a_perr, a_ferr, a_oerr, a_busy;
  logic       b_valid, b_perr, b_ferr, b_oerr, b_busy;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Expected word: {overrun, framing, parity, data[8:0]}
  logic [11:0] q_a[$];
  logic [11:0] q_b[$];

  always #5 clk = ~clk;

  uart_rx_param u_a (
    .bclkx8 (clk), .rst_n (rst_n), .rxd (rxd_a), .rx_ack (ack_a),
    .rx_data (a_data), .rx_valid (a_valid), .parity_err (a_perr),
    .framing_err (a_ferr), .overrun_err (a_oerr), .busy (a_busy)
  );

  uart_rx_param #(
    .DATA_BITS (7), .OVERSAMPLE (8), .PARITY_EN (1), .PARITY_ODD (0), .STOP_BITS (2)
  ) u_b (
    .bclkx8 (clk), .rst_n (rst_n), .rxd (rxd_b), .rx_ack (ack_b),
    .rx_data (b_data), .rx_valid (b_valid), .parity_err (b_perr),
    .framing_err (b_ferr), .overrun_err (b_oerr), .busy (b_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // A load shows as valid rising, or as changed contents while valid stays high.
  logic [11:0] pa, pb;
  logic        pva = 1'b0, pvb = 1'b0;

  always @(negedge clk) begin
    logic [11:0] act, exp;
    act = {a_oerr, a_ferr, a_perr, 1'b0, a_data};
    if (rst_n && a_valid && (!pva || act != pa)) begin
      n_cmp++;
      if (q_a.size() == 0) begin
        n_bad++;
        $display("FAIL mon_a unexpected word: got 0x%0h, expected none", act);
      end else begin
        exp = q_a.pop_front();
        if (act !== exp) begin
          n_bad++;
          $display("FAIL mon_a word: got 0x%0h, expected 0x%0h", act, exp);
        end
      end
    end
    pa  = act;
    pva = a_valid;
  end

  always @(negedge clk) begin
    logic [11:0] act, exp;
    act = {b_oerr, b_ferr, b_perr, 2'b00, b_data};
    if (rst_n && b_valid && (!pvb || act != pb)) begin
      n_cmp++;
      if (q_b.size() == 0) begin
        n_bad++;
        $display("FAIL mon_b unexpected word: got 0x%0h, expected none", act);
      end else begin
        exp = q_b.pop_front();
        if (act !== exp) begin
          n_bad++;
          $display("FAIL mon_b word: got 0x%0h, expected 0x%0h", act, exp);
        end
      end
    end
    pb  = act;
    pvb = b_valid;
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input bit use_b, input logic v);
    if (use_b) rxd_b = v;
    else       rxd_a = v;
  endtask

  task automatic set_ack(input bit use_b, input logic v);
    if (use_b) ack_b = v;
    else       ack_a = v;
  endtask

  task automatic ack_pulse(input bit use_b);
    set_ack(use_b, 1'b1);
    tick(1);
    set_ack(use_b, 1'b0);
    tick(1);
  endtask

  // 8 ticks per bit; optional ack held across the load edge of this frame.
  task automatic send_frame(input bit use_b, input logic [8:0] data, input int unsigned nbits,
                            input bit par_en, input logic par_bit, input int unsigned nstop,
                            input logic last_stop, input bit ack_at_load);
    drive(use_b, 1'b0);
    tick(8);
    for (int unsigned i = 0; i < nbits; i++) begin
      drive(use_b, data[i]);
      tick(8);
    end
    if (par_en) begin
      drive(use_b, par_bit);
      tick(8);
    end
    for (int unsigned s = 0; s < nstop; s++) begin
      drive(use_b, (s == nstop - 1) ? last_stop : 1'b1);
      if ((s == nstop - 1) && ack_at_load) begin
        tick(7);
        set_ack(use_b, 1'b1);
        tick(1);
        set_ack(use_b, 1'b0);
      end else begin
        tick(8);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    rxd_a = 1'b1; rxd_b = 1'b1;
    ack_a = 1'b0; ack_b = 1'b0;
    tick(3);
    chk("reset_a_data",  32'(a_data), 32'h0);
    chk("reset_a_flags", 32'({a_valid, a_perr, a_ferr, a_oerr, a_busy}), 32'h0);
    chk("reset_b_flags", 32'({b_valid, b_perr, b_ferr, b_oerr, b_busy}), 32'h0);
    rst_n = 1'b1;
    tick(4);

    // Default frame 0xA5
    q_a.push_back({3'b000, 9'h0A5});
    send_frame(1'b0, 9'h0A5, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0);
    chk("a5_valid_at_stop_end", 32'(a_valid), 32'h1);
    tick(4);
    ack_pulse(1'b0);
    chk("a5_ack_clears_valid", 32'(a_valid), 32'h0);

    // Start glitch: 3 low ticks must be rejected
    drive(1'b0, 1'b0);
    tick(3);
    drive(1'b0, 1'b1);
    tick(1);
    chk("glitch_busy_hi", 32'(a_busy), 32'h1);
    tick(8);
    chk("glitch_busy_lo", 32'(a_busy), 32'h0);
    chk("glitch_no_valid", 32'(a_valid), 32'h0);

    // B: 0x41, 7 bits, wrong even parity bit
    q_b.push_back({3'b001, 9'h041});
    send_frame(1'b1, 9'h041, 7, 1'b1, 1'b1, 2, 1'b1, 1'b0);
    tick(4);
    ack_pulse(1'b1);
    chk("par_ack_clears_perr", 32'(b_perr), 32'h0);

    // Overrun sequence on A
    q_a.push_back({3'b000, 9'h011});
    send_frame(1'b0, 9'h011, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0);
    tick(4);
    q_a.push_back({3'b100, 9'h022});
    send_frame(1'b0, 9'h022, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0);
    tick(4);
    chk("ovr_set", 32'(a_oerr), 32'h1);
    q_a.push_back({3'b000, 9'h033});
    send_frame(1'b0, 9'h033, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    tick(2);
    chk("ack_on_load_valid", 32'(a_valid), 32'h1);
    chk("ack_on_load_ovr",   32'(a_oerr),  32'h0);
    ack_pulse(1'b0);
    chk("ovr_ack_valid", 32'(a_valid), 32'h0);
    ack_pulse(1'b0);
    chk("ack_idle_noop", 32'({a_valid, a_oerr}), 32'h0);

    // B: second stop low then line held low (break)
    q_b.push_back({3'b010, 9'h02A});
    send_frame(1'b1, 9'h02A, 7, 1'b1, 1'b1, 2, 1'b0, 1'b0);
    tick(30);
    chk("break_busy", 32'(b_busy), 32'h1);
    chk("break_ferr", 32'(b_ferr), 32'h1);
    drive(1'b1, 1'b1);
    tick(5);
    chk("break_release", 32'(b_busy), 32'h0);
    ack_pulse(1'b1);
    q_b.push_back({3'b000, 9'h015});
    send_frame(1'b1, 9'h015, 7, 1'b1, 1'b1, 2, 1'b1, 1'b0);
    tick(4);

    // A: unacked word, then reset in the middle of frame 0x3C
    q_a.push_back({3'b000, 9'h077});
    send_frame(1'b0, 9'h077, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0);
    tick(4);
    drive(1'b0, 1'b0); tick(8);
    drive(1'b0, 1'b0); tick(8);
    drive(1'b0, 1'b0); tick(8);
    drive(1'b0, 1'b1); tick(3);
    chk("pre_reset_busy", 32'(a_busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("midreset_data",  32'(a_data), 32'h0);
    chk("midreset_flags", 32'({a_valid, a_perr, a_ferr, a_oerr, a_busy}), 32'h0);
    chk("midreset_b",     32'({b_valid, b_busy}), 32'h0);
    drive(1'b0, 1'b1);
    tick(4);
    rst_n = 1'b1;
    tick(4);
    q_a.push_back({3'b000, 9'h05A});
    send_frame(1'b0, 9'h05A, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0);
    tick(6);

    chk("q_a_drained", 32'(q_a.size()), 32'h0);
    chk("q_b_drained", 32'(q_b.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
